// File: rtl/rca8_serial_sub_if.sv
// Request/result bundle for the bit-serial subtractor rca8_serial_sub.
// RCA8_SERIAL_SUB_OVF_EN adds the signed-overflow flag Ovf.
interface rca8_serial_sub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
`ifdef RCA8_SERIAL_SUB_OVF_EN
   logic             Ovf;

   modport master (output Start, A, B, Bin, input Busy, Done, Diff, Bout, Ovf);
   modport slave  (input Start, A, B, Bin, output Busy, Done, Diff, Bout, Ovf);
`else
   modport master (output Start, A, B, Bin, input Busy, Done, Diff, Bout);
   modport slave  (input Start, A, B, Bin, output Busy, Done, Diff, Bout);
`endif
endinterface

// File: rtl/rca8_serial_sub.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Define RCA8_SERIAL_SUB_OVF_EN to add the registered signed-overflow output Ovf.
module rca8_serial_sub #(
   parameter int unsigned WIDTH = 8
) (
   input logic              Clk,
   input logic              Reset_n,
   rca8_serial_sub_if.slave s
);
   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_diff;
   logic [CNT_W-1:0] r_cnt;
   logic             r_br;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;

   logic             w_a;
   logic             w_b;
   logic             w_d;
   logic             w_br_nxt;
   logic             w_last;
   logic             w_accept;

   // One full-subtractor bit slice on the operand LSBs
   assign w_a      = r_a_sh[0];
   assign w_b      = r_b_sh[0];
   assign w_d      = w_a ^ w_b ^ r_br;
   assign w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   // Busy/Done are registered from the state, so the cycle in which Done is
   // visible is internally IDLE and a Start there chains the next operation.
   assign w_accept = (r_state == S_IDLE) && s.Start;

   always_ff @(posedge Clk) begin : state_reg
      if (!Reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin : next_state
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (s.Start) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last)  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef RCA8_SERIAL_SUB_OVF_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;
`endif

   always_ff @(posedge Clk) begin : datapath
      if (!Reset_n) begin
         r_a_sh <= '0;
         r_b_sh <= '0;
         r_diff <= '0;
         r_cnt  <= '0;
         r_br   <= 1'b0;
         r_bout <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
`ifdef RCA8_SERIAL_SUB_OVF_EN
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_busy <= (r_state == S_SHIFT);
         r_done <= (r_state == S_DONE);
         if (w_accept) begin
            r_a_sh <= s.A;
            r_b_sh <= s.B;
            r_br   <= s.Bin;
            r_cnt  <= '0;
`ifdef RCA8_SERIAL_SUB_OVF_EN
            r_a_msb <= s.A[WIDTH-1];
            r_b_msb <= s.B[WIDTH-1];
`endif
         end else if (r_state == S_SHIFT) begin
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_br   <= w_br_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_bout <= w_br_nxt;
`ifdef RCA8_SERIAL_SUB_OVF_EN
               // w_d is the final Diff MSB on the last bit
               r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
            end
         end
      end
   end

   assign s.Busy = r_busy;
   assign s.Done = r_done;
   assign s.Diff = r_diff;
   assign s.Bout = r_bout;
`ifdef RCA8_SERIAL_SUB_OVF_EN
   assign s.Ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_rca8_serial_sub.sv
// Directed self-checking bench for rca8_serial_sub (WIDTH=8); checks Ovf
// when RCA8_SERIAL_SUB_OVF_EN is defined.
module tb_rca8_serial_sub;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   rca8_serial_sub_if #(.WIDTH(8)) bus ();

   rca8_serial_sub #(.WIDTH(8)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .s       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive a request at the current negedge; return one cycle after the sampling edge
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
      bus.Start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.Bin   = bin;
      @(negedge clk);
      bus.Start = 1'b0;
      bus.A     = ~a;
      bus.B     = ~b;
      bus.Bin   = ~bin;
      check({tag, "_busy_e0"}, 32'(bus.Busy), 32'd0);
   endtask

   // Busy after edges 1..8, Done with result after edge 9; optional Start pulse at cycle pulse_at
   task automatic expect_result(input string tag, input logic [7:0] diff, input logic bout,
                                input logic ovf, input int pulse_at);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.Start = (k == pulse_at);
         if (k == pulse_at) begin
            bus.A = 8'h55;
            bus.B = 8'h22;
         end
         check({tag, "_busy"}, 32'({bus.Busy, bus.Done}), 32'b10);
      end
      @(negedge clk);
      bus.Start = 1'b0;
      check({tag, "_done"}, 32'({bus.Busy, bus.Done}), 32'b01);
      check({tag, "_diff"}, 32'(bus.Diff), 32'(diff));
      check({tag, "_bout"}, 32'(bus.Bout), 32'(bout));
`ifdef RCA8_SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(bus.Ovf), 32'(ovf));
`else
      if (ovf === 1'bx) n_err++;
`endif
   endtask

   task automatic expect_hold(input string tag, input logic [7:0] diff, input logic bout);
      @(negedge clk);
      check({tag, "_hold_done"}, 32'({bus.Busy, bus.Done}), 32'b00);
      check({tag, "_hold_diff"}, 32'({bus.Diff, bus.Bout}), 32'({diff, bout}));
   endtask

   initial begin
      int pulses;
      n_chk     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bus.Start = 1'b1;
      bus.A     = 8'hAA;
      bus.B     = 8'h55;
      bus.Bin   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outs", 32'({bus.Busy, bus.Done, bus.Diff, bus.Bout}), 32'd0);
      bus.Start = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      check("reset_idle", 32'({bus.Busy, bus.Done}), 32'd0);

      launch(8'h03, 8'h01, 1'b0, "t1");
      expect_result("t1", 8'h02, 1'b0, 1'b0, 0);
      expect_hold("t1", 8'h02, 1'b0);

      launch(8'h01, 8'h02, 1'b0, "t2");
      expect_result("t2", 8'hFF, 1'b1, 1'b0, 0);
      expect_hold("t2", 8'hFF, 1'b1);

      launch(8'h2F, 8'h81, 1'b1, "t3");
      expect_result("t3", 8'hAD, 1'b1, 1'b1, 0);
      expect_hold("t3", 8'hAD, 1'b1);

      // Back-to-back: second Start issued in the Done cycle
      launch(8'h00, 8'h00, 1'b1, "t4a");
      expect_result("t4a", 8'hFF, 1'b1, 1'b0, 0);
      launch(8'h08, 8'h02, 1'b0, "t4b");
      expect_result("t4b", 8'h06, 1'b0, 1'b0, 0);
      expect_hold("t4b", 8'h06, 1'b0);

      // Start pulsed mid-operation is ignored
      launch(8'h10, 8'h01, 1'b0, "t5");
      expect_result("t5", 8'h0F, 1'b0, 1'b0, 3);
      expect_hold("t5", 8'h0F, 1'b0);

      // Reset during SHIFT aborts with no Done pulse
      launch(8'h33, 8'h11, 1'b0, "t6");
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("t6_busy", 32'(bus.Busy), 32'd1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_outs", 32'({bus.Busy, bus.Done, bus.Diff, bus.Bout}), 32'd0);
      rst_n  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.Done === 1'b1 || bus.Busy === 1'b1) pulses++;
      end
      check("t6_no_done", 32'(pulses), 32'd0);
      check("t6_diff_clr", 32'({bus.Diff, bus.Bout}), 32'd0);

      launch(8'h80, 8'h01, 1'b0, "t7");
      expect_result("t7", 8'h7F, 1'b0, 1'b1, 0);
      launch(8'h05, 8'h03, 1'b0, "t8");
      expect_result("t8", 8'h02, 1'b0, 1'b0, 0);
      expect_hold("t8", 8'h02, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/rca8_serial_sub.md
Name: rca8_serial_sub

Overview:
- Bit-serial subtractor computing Diff = A - B - Bin, one bit per clock, LSB first.
- It is the inverse-operation counterpart to the 8-bit ripple carry adder. It uses the same operand/flag naming (A, B, borrow-in/out in place of Cin/Cout).
- Trades the adder's combinational ripple for a small registered datapath with a start/done handshake.
- Sits beside the adder in the arithmetic block; results are cross-checkable against it via the two's-complement identity.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  synchronous active-low reset.
- Start  input  1  request; sampled only in IDLE or DONE state.
- A  input  WIDTH  minuend; captured on accepted Start.
- B  input  WIDTH  subtrahend; captured on accepted Start.
- Bin  input  1  borrow-in; captured on accepted Start.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse; result valid.
- Diff  output  WIDTH  difference, registered.
- Bout  output  1  borrow-out (1 when A < B + Bin, unsigned).

Behaviour:
- Reset (Reset_n low at a rising Clk edge): state=IDLE; Busy=0, Done=0, Diff=0, Bout=0; internal A/B shift registers, borrow and bit counter cleared. Reset overrides Start.
- States: IDLE, SHIFT, DONE.
- IDLE: on Start=1, capture A, B, Bin; counter=0; go to SHIFT. Start=0: stay.
- SHIFT: Busy=1. Each cycle processes operand bit a=A_sh[0], b=B_sh[0] with current borrow br:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - d shifts into Diff register from MSB side (shift right); A_sh and B_sh shift right; counter++.
  - After the WIDTH-th bit (counter==WIDTH-1), load Bout=br_next and go to DONE.
- DONE: Done=1 for exactly this cycle, Busy=0, then IDLE.
  - Start=1 in DONE is accepted exactly as in IDLE, going straight to SHIFT (back-to-back operation).
- Latency: Start sampled at edge 0; Busy high after edges 1..WIDTH; Done high after edge WIDTH+1. For WIDTH=8, Done is visible in the cycle following edge 9.
- Start during SHIFT is ignored. Captured operands are unaffected, and A/B/Bin changes during SHIFT have no effect.
- Diff/Bout are held stable from Done until the next accepted Start. Diff contents are undefined (partial) while Busy=1; the bench checks only at Done.
- Reset mid-SHIFT: abort immediately, all outputs to reset values, no Done pulse.
- Wrap-around: results are modulo 2^WIDTH; borrow out of the MSB goes to Bout only.

Optional Feature:
- Macro RCA8_SERIAL_SUB_OVF_EN.
- Defined: adds output port Ovf (1 bit), registered with Bout.
  - Ovf = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]), using the captured operands and the final Diff, i.e. signed two's-complement overflow.
  - Reset value 0; held like Diff.
- Undefined: Ovf port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then A=0x03, B=0x01, Bin=0, Start pulse -> Busy for 8 cycles, Done at edge 9, Diff=0x02, Bout=0.
- A=0x01, B=0x02, Bin=0 -> Diff=0xFF, Bout=1.
- A=0x2F, B=0x81, Bin=1 -> Diff=0xAD, Bout=1.
- A=0x00, B=0x00, Bin=1, plus Start re-asserted in the DONE cycle with A=0x08, B=0x02 -> first Diff=0xFF, Bout=1; second op starts with no idle gap, Diff=0x06, Bout=0.
- Start with A=0x10, B=0x01; pulse Start with different operands at cycle 3; drop Reset_n at cycle 5 of a second op -> first result 0x0F unaffected; after reset, Busy=Done=0, Diff=0x00, Bout=0, and no Done pulse.
- With RCA8_SERIAL_SUB_OVF_EN: A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0, Ovf=1; A=0x05, B=0x03 -> Ovf=0.
